// File: rtl/iter_divider.sv
// Iterative 32-bit integer divider: signed/unsigned quotient or remainder,
// restoring radix-2, one quotient bit per cycle, with optional fast path
// for divide-by-zero and signed overflow.
//
// Handshake: div_ready is high only while idle; a request is taken on a
// rising edge where div_req=1, div_ready=1 and div_flush=0. div_valid is a
// single-cycle pulse in the DONE state (suppressed by div_flush) and
// div_result holds its value until the next completion.
module iter_divider #(
  parameter bit SPECIAL_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req,
  output logic        div_ready,
  input  logic [1:0]  div_type,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        div_flush,
  output logic        div_valid,
  output logic [31:0] div_result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    SS_DIV = 2'b00,
    UU_DIV = 2'b01,
    SS_REM = 2'b10,
    UU_REM = 2'b11
  } div_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  count;
  logic [31:0] quo_q;    // dividend bits shifted out MSB first, quotient shifted in
  logic [31:0] rem_q;    // partial remainder, always below the divisor magnitude
  logic [31:0] dvsr_q;   // divisor magnitude
  logic        q_neg_q;
  logic        r_neg_q;
  logic        sel_rem_q;

  div_type_t   op;
  logic        is_signed;
  logic        want_rem;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        b_zero;
  logic        ovf;
  logic        special;
  logic [31:0] special_res;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        take;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic [31:0] res_fin;

  assign div_ready = (state == IDLE);
  assign div_valid = (state == DONE) && !div_flush;
  assign dbg_state = state;

  // Operand decode at the accept point: magnitudes, signs and special cases.
  always_comb begin
    op          = div_type_t'(div_type);
    is_signed   = (op == SS_DIV) || (op == SS_REM);
    want_rem    = (op == SS_REM) || (op == UU_REM);
    a_neg       = is_signed && div_a[31];
    b_neg       = is_signed && div_b[31];
    a_mag       = a_neg ? (~div_a + 32'd1) : div_a;
    b_mag       = b_neg ? (~div_b + 32'd1) : div_b;
    b_zero      = (div_b == 32'd0);
    ovf         = is_signed && (div_a == 32'h8000_0000) && (div_b == 32'hFFFF_FFFF);
    special     = b_zero || ovf;
    special_res = 32'd0;
    if (b_zero) begin
      special_res = want_rem ? div_a : 32'hFFFF_FFFF;
    end else begin
      special_res = want_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring step plus sign fix-up of the would-be final values.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dvsr_q};
    take      = !diff[32];
    rem_nxt   = take ? diff[31:0] : rem_shift[31:0];
    quo_nxt   = {quo_q[30:0], take};
    q_fin     = q_neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
    r_fin     = r_neg_q ? (~rem_nxt + 32'd1) : rem_nxt;
    res_fin   = sel_rem_q ? r_fin : q_fin;
  end

  // Control FSM with datapath registers; flush wins over everything but reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 6'd0;
      quo_q      <= 32'd0;
      rem_q      <= 32'd0;
      dvsr_q     <= 32'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      sel_rem_q  <= 1'b0;
      div_result <= 32'd0;
    end else if (div_flush) begin
      state <= IDLE;
      count <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (div_req) begin
            count     <= 6'd0;
            quo_q     <= a_mag;
            rem_q     <= 32'd0;
            dvsr_q    <= b_mag;
            // Divide-by-zero must give an all-ones quotient regardless of sign.
            q_neg_q   <= (a_neg ^ b_neg) && !b_zero;
            r_neg_q   <= a_neg;
            sel_rem_q <= want_rem;
            if (SPECIAL_BYPASS && special) begin
              div_result <= special_res;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            div_result <= res_fin;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: two instances (fast path on and off) share one
// stimulus stream; expected results are queued at issue and popped by a
// monitor whenever a div_valid pulse appears.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req;
  logic        div_flush;
  logic [1:0]  div_type;
  logic [31:0] div_a;
  logic [31:0] div_b;

  logic        ready1, valid1, ready0, valid0;
  logic [31:0] result1, result0;
  logic [1:0]  st1, st0;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q0[$];
  logic        prev_v1 = 1'b0;
  logic        prev_v0 = 1'b0;

  localparam logic [1:0] T_SS_DIV = 2'b00;
  localparam logic [1:0] T_UU_DIV = 2'b01;
  localparam logic [1:0] T_SS_REM = 2'b10;
  localparam logic [1:0] T_UU_REM = 2'b11;

  // clock / reset block
  always #5 clk = ~clk;

  iter_divider #(.SPECIAL_BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .div_req(div_req), .div_ready(ready1),
    .div_type(div_type), .div_a(div_a), .div_b(div_b), .div_flush(div_flush),
    .div_valid(valid1), .div_result(result1), .dbg_state(st1)
  );

  iter_divider #(.SPECIAL_BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .div_req(div_req), .div_ready(ready0),
    .div_type(div_type), .div_a(div_a), .div_b(div_b), .div_flush(div_flush),
    .div_valid(valid0), .div_result(result0), .dbg_state(st0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic plus the two special rules.
  function automatic logic [31:0] model(input logic [1:0] t, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    sgn = (t == T_SS_DIV) || (t == T_SS_REM);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return (t == T_SS_REM || t == T_UU_REM) ? r : q;
  endfunction

  // Scoreboard monitor: pop and compare on every valid pulse.
  always @(negedge clk) begin
    if (valid1) begin
      if (exp_q1.size() == 0) check("spurious_valid1", 32'(valid1), 32'd0);
      else check("result1", result1, exp_q1.pop_front());
      check("valid_pulse1", 32'(prev_v1), 32'd0);
    end
    if (valid0) begin
      if (exp_q0.size() == 0) check("spurious_valid0", 32'(valid0), 32'd0);
      else check("result0", result0, exp_q0.pop_front());
      check("valid_pulse0", 32'(prev_v0), 32'd0);
    end
    prev_v1 = valid1;
    prev_v0 = valid0;
  end

  // Driver: called at a negedge with both units idle; returns at a negedge.
  task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int   lat1, lat0, c1, c0;
    logic special, busy_bad;
    special  = (b == 32'd0) ||
               ((t == T_SS_DIV || t == T_SS_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    lat0     = 33;
    lat1     = special ? 1 : 33;
    c1       = -1;
    c0       = -1;
    busy_bad = 1'b0;
    check("ready_before", {30'd0, ready1, ready0}, 32'h3);
    div_req  = 1'b1;
    div_type = t;
    div_a    = a;
    div_b    = b;
    exp_q1.push_back(exp);
    exp_q0.push_back(exp);
    @(posedge clk);
    #1;
    div_req  = 1'b0;
    div_type = 2'($urandom);
    div_a    = $urandom;
    div_b    = $urandom;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (valid1 && c1 < 0) c1 = k;
      if (valid0 && c0 < 0) c0 = k;
      if (k <= lat1 && ready1) busy_bad = 1'b1;
      if (k <= lat0 && ready0) busy_bad = 1'b1;
      if (k == lat1 + 1) check("ready_after1", 32'(ready1), 32'd1);
      if (k == lat0 + 1) check("ready_after0", 32'(ready0), 32'd1);
    end
    check("busy_ready", 32'(busy_bad), 32'd0);
    check("latency1", c1, lat1);
    check("latency0", c0, lat0);
  endtask

  initial begin
    logic [1:0]  t;
    logic [31:0] a, b;
    logic [31:0] save1, save0;
    int          sel;

    rst = 1'b1; div_req = 1'b0; div_flush = 1'b0;
    div_type = 2'd0; div_a = 32'd0; div_b = 32'd0;
    @(negedge clk);
    check("rst_ready", {30'd0, ready1, ready0}, 32'h3);
    check("rst_valid", {30'd0, valid1, valid0}, 32'h0);
    check("rst_result1", result1, 32'd0);
    check("rst_result0", result0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // first request right on the first edge after reset release
    run_op(T_UU_DIV, 32'd100, 32'd7, 32'd14);
    run_op(T_UU_REM, 32'd100, 32'd7, 32'd2);
    run_op(T_SS_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(T_SS_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op(T_SS_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_op(T_UU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op(T_UU_REM, 32'd5, 32'd0, 32'd5);
    run_op(T_SS_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run_op(T_SS_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run_op(T_SS_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(T_SS_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op(T_UU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      t   = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = $urandom_range(1, 15);
      if (sel == 3) b = -32'($urandom_range(1, 15));
      run_op(t, a, b, model(t, a, b));
    end

    // flush mid-calculation at T+10
    save1 = result1; save0 = result0;
    div_req = 1'b1; div_type = T_UU_DIV; div_a = $urandom; div_b = $urandom | 32'd1;
    @(posedge clk);
    #1 div_req = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    div_flush = 1'b1;
    @(posedge clk);
    #1 div_flush = 1'b0;
    @(negedge clk);
    check("flush_ready", {30'd0, ready1, ready0}, 32'h3);
    check("flush_result1", result1, save1);
    check("flush_result0", result0, save0);

    // flush together with a request in idle must not accept it
    div_req = 1'b1; div_flush = 1'b1; div_type = T_UU_DIV; div_a = 32'd9; div_b = 32'd0;
    @(posedge clk);
    #1 begin div_req = 1'b0; div_flush = 1'b0; end
    @(negedge clk);
    check("flush_req_ready", {30'd0, ready1, ready0}, 32'h3);
    repeat (40) @(negedge clk);
    run_op(T_UU_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);

    // asynchronous reset at T+20
    div_req = 1'b1; div_type = T_UU_REM; div_a = $urandom; div_b = $urandom | 32'd1;
    @(posedge clk);
    #1 div_req = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_valid", {30'd0, valid1, valid0}, 32'h0);
    check("arst_ready", {30'd0, ready1, ready0}, 32'h3);
    check("arst_result1", result1, 32'd0);
    check("arst_result0", result0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_op(T_SS_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);

    check("queue_empty", 32'(exp_q1.size() + exp_q0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 The block SHALL have parameter: SPECIAL_BYPASS, 1, divide-by-zero and signed overflow complete without iterating.
REQ-002 The block SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: div_req  input  1  request valid.
REQ-005 The block SHALL have port: div_ready  output  1  unit idle, request accepted this cycle if div_req=1.
REQ-006 The block SHALL have port: div_type  input  2  operation, div_type_t encoding: ss_div=00, uu_div=01, ss_rem=10, uu_rem=11.
REQ-007 The block SHALL have port: div_a  input  32  dividend.
REQ-008 The block SHALL have port: div_b  input  32  divisor.
REQ-009 The block SHALL have port: div_flush  input  1  abort any operation in progress.
REQ-010 The block SHALL have port: div_valid  output  1  one-cycle pulse, div_result valid.
REQ-011 The block SHALL have port: div_result  output  32  quotient or remainder.

Function
REQ-012 The block SHALL implement states IDLE, CALC and DONE.
REQ-013 div_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted when div_req=1, div_ready=1 and div_flush=0; accepting captures div_type, div_a and div_b, and the block ignores them afterwards.
REQ-015 Requests in CALC or DONE SHALL be ignored, without being queued.
REQ-016 On accept, signed types SHALL latch operand magnitudes plus quotient sign (sign_a XOR sign_b) and remainder sign (sign_a); unsigned types SHALL latch raw operands.
REQ-017 CALC SHALL perform restoring radix-2 division, one quotient bit per cycle, MSB first, with a 6-bit counter running exactly 32 iterations, then go to DONE.
REQ-018 In DONE, the quotient and remainder SHALL be negated (two's complement) where their latched signs require it.
REQ-019 div_result SHALL carry the quotient for ss_div/uu_div and the remainder for ss_rem/uu_rem.
REQ-020 div_result SHALL be registered and valid in the DONE cycle with div_valid=1, then go to IDLE.
REQ-021 div_result SHALL hold its value until the next DONE.
REQ-022 Latency: accept at cycle T, CALC T+1..T+32, div_valid at T+33, div_ready=1 again at T+34.
REQ-023 Divide by zero (div_b=0) SHALL give quotient 0xFFFFFFFF and remainder div_a, for signed and unsigned types.
REQ-024 Signed overflow (ss_div or ss_rem with div_a=0x80000000, div_b=0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-025 With SPECIAL_BYPASS=1, the cases in REQ-023 and REQ-024 SHALL go IDLE->DONE with div_valid at T+1.
REQ-026 With SPECIAL_BYPASS=0, those cases SHALL run the full 32 iterations and give the same results.
REQ-027 div_flush=1 in any state SHALL force IDLE at the next edge with no div_valid, including in the DONE cycle, where div_valid is suppressed.
REQ-028 div_flush with div_req in IDLE SHALL not accept the request.
REQ-029 div_result SHALL be unchanged by a flush.
REQ-030 div_valid SHALL never assert two consecutive cycles.
REQ-031 div_valid SHALL never assert without a prior accepted, unflushed request.

Reset
REQ-032 While rst=1, asynchronously: state IDLE, div_ready=1, div_valid=0, div_result=0, counter and internal registers 0.
REQ-033 rst asserted mid-CALC SHALL abort the operation with no div_valid after release.
REQ-034 The first request SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-035 The bench SHALL cover: uu_div 100/7 -> div_result=14 at T+33; uu_rem 100/7 -> 2; div_ready=0 for T+1..T+33.
REQ-036 The bench SHALL cover: ss_div 0xFFFFFFF9/2 -> 0xFFFFFFFD; ss_rem same operands -> 0xFFFFFFFF; ss_div 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-037 The bench SHALL cover, with SPECIAL_BYPASS=1: uu_div 5/0 -> 0xFFFFFFFF at T+1; uu_rem 5/0 -> 5; ss_rem 0xFFFFFFFB/0 -> 0xFFFFFFFB.
REQ-038 The bench SHALL cover: ss_div 0x80000000/0xFFFFFFFF -> 0x80000000; ss_rem -> 0; repeat with SPECIAL_BYPASS=0 -> same values at T+33.
REQ-039 The bench SHALL cover: flush at cycle T+10 -> no div_valid, div_ready=1 at T+11; new uu_div 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.
REQ-040 The bench SHALL cover: rst pulse at T+20 -> div_valid=0, div_result=0 and div_ready=1 immediately; no div_valid over the next 40 cycles.
